// File: rtl/lsu_agu_if.sv
// lsu_agu_if: bundles the execute-side, memory-side and writeback-side
// handshakes of the load/store front-end.
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where both valid and ready are high. A valid, once raised, holds and its
// payload stays stable until that edge. The read response (mem_rvalid) has no
// ready; it is a one-cycle pulse.
interface lsu_agu_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic              in_store;
   logic [2:0]        in_funct3;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] in_imm;
   logic [31:0]       in_wdata;
   logic [4:0]        in_rd;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_wdata;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [4:0]        out_rd;
   logic              out_wen;
   logic              out_err;

   // The load/store unit itself.
   modport slave (
      input  in_valid, in_store, in_funct3, in_base, in_imm, in_wdata, in_rd,
      output in_ready,
      output mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata,
      output out_valid, out_data, out_rd, out_wen, out_err,
      input  out_ready
   );

   // The surroundings: execute stage, memory port and writeback.
   modport master (
      output in_valid, in_store, in_funct3, in_base, in_imm, in_wdata, in_rd,
      input  in_ready,
      input  mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata,
      input  out_valid, out_data, out_rd, out_wen, out_err,
      output out_ready
   );
endinterface

// File: rtl/lsu_agu.sv
// lsu_agu: load/store front-end. Computes base+imm, issues one word-aligned
// memory request with byte mask and lane-replicated store data, then extracts
// and extends the load result for writeback. One op in flight:
// IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word ops skip the
// memory request and complete straight away with out_err=1.
module lsu_agu #(
   parameter int ADDR_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   lsu_agu_if.slave   bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] ea;
   logic [1:0]        off_raw;
   logic [1:0]        off_eff;
   logic              is_byte, is_half, is_word;
   logic              misalign;
   logic              accept;
   logic [3:0]        size_mask;
   logic [7:0]        mask_wide;
   logic [3:0]        lane_mask;
   logic [31:0]       lane_data;

   logic              store_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [4:0]        rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [3:0]        wmask_q;
   logic [31:0]       wdata_q;
   logic [31:0]       out_data_q;
   logic              out_wen_q;
   logic              out_err_q;

   logic [31:0]       raw;
   logic [31:0]       rdata_ext;

   assign ea      = bus.in_base + bus.in_imm;
   assign off_raw = ea[1:0];
   assign accept  = (state_q == S_IDLE) && bus.in_valid;

   // Decode access size; word ops always use lane 0, and a halfword at
   // offset 3 keeps only the lane-3 bit of its shifted mask.
   always_comb begin
      is_byte   = (bus.in_funct3[1:0] == 2'b00);
      is_half   = (bus.in_funct3[1:0] == 2'b01);
      is_word   = !is_byte && !is_half;
      off_eff   = is_word ? 2'b00 : off_raw;
      size_mask = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
      mask_wide = {4'b0000, size_mask} << off_eff;
      lane_mask = mask_wide[3:0];
      if (is_byte) begin
         lane_data = {4{bus.in_wdata[7:0]}};
      end else if (is_half) begin
         lane_data = {2{bus.in_wdata[15:0]}};
      end else begin
         lane_data = bus.in_wdata;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = (is_half && off_raw[0]) || (is_word && (off_raw != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   // Shift the returned word down by the byte offset and extend it.
   always_comb begin
      raw = bus.mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  rdata_ext = {{24{raw[7]}}, raw[7:0]};
         3'b001:  rdata_ext = {{16{raw[15]}}, raw[15:0]};
         3'b100:  rdata_ext = {24'd0, raw[7:0]};
         3'b101:  rdata_ext = {16'd0, raw[15:0]};
         default: rdata_ext = raw;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the response is only looked at in WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.in_valid)   state_d = misalign ? S_RESP : S_REQ;
         S_REQ:  if (bus.mem_ready)  state_d = S_WAIT;
         S_WAIT: if (bus.mem_rvalid) state_d = S_RESP;
         S_RESP: if (bus.out_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Latch the request at accept and the load result when the response lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         store_q    <= 1'b0;
         f3_q       <= 3'd0;
         off_q      <= 2'd0;
         rd_q       <= 5'd0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wmask_q    <= 4'd0;
         wdata_q    <= 32'd0;
         out_data_q <= 32'd0;
         out_wen_q  <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            store_q    <= bus.in_store;
            f3_q       <= bus.in_funct3;
            off_q      <= off_eff;
            rd_q       <= bus.in_rd;
            addr_q     <= {ea[ADDR_W-1:2], 2'b00};
            wen_q      <= bus.in_store;
            wmask_q    <= bus.in_store ? lane_mask : 4'b0000;
            wdata_q    <= lane_data;
            out_data_q <= 32'd0;
            out_wen_q  <= !bus.in_store && !misalign;
            out_err_q  <= misalign;
         end
         if ((state_q == S_WAIT) && bus.mem_rvalid && !store_q) begin
            out_data_q <= rdata_ext;
         end
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.mem_valid = (state_q == S_REQ);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wen   = wen_q;
   assign bus.mem_wmask = wmask_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.out_valid = (state_q == S_RESP);
   assign bus.out_data  = out_data_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_wen   = out_wen_q;
   assign bus.out_err   = out_err_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_agu.sv
// tb_lsu_agu: randomized scoreboard bench for lsu_agu. The issuing task
// pushes expected memory requests and writeback results computed by a
// behavioural model; a monitor pops and compares on every handshake.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_lsu_agu;
   localparam int ADDR_W = 32;
   localparam int OUT_W  = 39;  // {data, rd, wen, err}
   localparam int MEM_W  = 69;  // {addr, wen, mask, wdata}

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   lsu_agu_if #(.ADDR_W(ADDR_W)) bus ();

   lsu_agu #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [OUT_W-1:0] exp_q[$];
   logic [MEM_W-1:0] exp_mem_q[$];
   logic [31:0]      rdata_q[$];

   int rdy_pct  = 100;
   int rv_pct   = 100;
   int out_pct  = 100;
   bit resp_auto = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        output bit has_mem, output logic [MEM_W-1:0] mem_pkt,
                        output logic [OUT_W-1:0] out_pkt);
      logic [31:0] addr;
      logic [31:0] lanes;
      logic [31:0] res;
      logic [63:0] t;
      logic [3:0]  mask;
      longint      v;
      longint      span;
      int          nbytes;
      int          off;
      bit          sgn;
      bit          mis;
      addr = base + imm;
      off  = int'(addr[1:0]);
      case (f3)
         3'b000, 3'b100: nbytes = 1;
         3'b001, 3'b101: nbytes = 2;
         default:        nbytes = 4;
      endcase
      sgn = (f3 == 3'b000) || (f3 == 3'b001);
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (off % nbytes) != 0;
`endif
      if (nbytes == 4) off = 0;
      mask = 4'(((1 << nbytes) - 1) << off);
      if (nbytes == 1)      lanes = {24'd0, wdata[7:0]} * 32'h0101_0101;
      else if (nbytes == 2) lanes = {16'd0, wdata[15:0]} * 32'h0001_0001;
      else                  lanes = wdata;
      span = longint'(1) << (8 * nbytes);
      t = {32'd0, rdata} >> (8 * off);
      v = longint'(t) % span;
      if (sgn && (nbytes < 4) && (v >= span / 2)) v = v - span;
      res = v[31:0];
      has_mem = !mis;
      if (st) mem_pkt = {addr & 32'hFFFF_FFFC, 1'b1, mask, lanes};
      else    mem_pkt = {addr & 32'hFFFF_FFFC, 1'b0, 4'b0000, 32'd0};
      if (mis)     out_pkt = {32'd0, rd, 1'b0, 1'b1};
      else if (st) out_pkt = {32'd0, rd, 1'b0, 1'b0};
      else         out_pkt = {res, rd, 1'b1, 1'b0};
   endtask

   // ---------------- driver ----------------
   task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] rdata);
      bit               has_mem;
      logic [MEM_W-1:0] mp;
      logic [OUT_W-1:0] op;
      int               waited;
      model(st, f3, base, imm, wdata, rdata, rd, has_mem, mp, op);
      if (has_mem) begin
         exp_mem_q.push_back(mp);
         rdata_q.push_back(rdata);
      end
      exp_q.push_back(op);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_store  = st;
      bus.in_funct3 = f3;
      bus.in_base   = base;
      bus.in_imm    = imm;
      bus.in_wdata  = wdata;
      bus.in_rd     = rd;
      waited = 0;
      #2;
      while (!bus.in_ready && waited < 300) begin
         @(negedge clk);
         #2;
         waited++;
      end
      if (!bus.in_ready) begin
         n_total++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1 within 300 cycles");
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_base  = $urandom;
      bus.in_wdata = $urandom;
   endtask

   task automatic drain(input string tag);
      int waited;
      waited = 0;
      while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_out_q_empty"}, exp_q.size(), 0);
      check({tag, "_mem_q_empty"}, exp_mem_q.size(), 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"},     dbg_state, 0);
      check({tag, "_in_ready"},  bus.in_ready, 1);
      check({tag, "_mem_valid"}, bus.mem_valid, 0);
      check({tag, "_mem_wen"},   bus.mem_wen, 0);
      check({tag, "_mem_wmask"}, bus.mem_wmask, 0);
      check({tag, "_mem_addr"},  bus.mem_addr, 0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_wen"},   bus.out_wen, 0);
      check({tag, "_out_err"},   bus.out_err, 0);
      check({tag, "_out_data"},  bus.out_data, 0);
      check({tag, "_out_rd"},    bus.out_rd, 0);
   endtask

   // ---------------- memory responder ----------------
   bit          pending = 1'b0;
   logic [31:0] cur_rdata = 32'd0;

   initial begin
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         if (resp_auto) begin
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (pending) begin
               if ($urandom_range(0, 99) < rv_pct) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = cur_rdata;
                  pending        = 1'b0;
               end
            end else if (bus.mem_valid) begin
               // Stray responses while the request is pending must be ignored.
               bus.mem_rvalid = ($urandom_range(0, 99) < 20);
               if ($urandom_range(0, 99) < rdy_pct) begin
                  bus.mem_ready = 1'b1;
                  pending       = 1'b1;
                  if (rdata_q.size() != 0) cur_rdata = rdata_q.pop_front();
               end
            end else begin
               bus.mem_rvalid = ($urandom_range(0, 99) < 10);
            end
         end
      end
   end

   // ---------------- writeback ready ----------------
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.out_ready = ($urandom_range(0, 99) < out_pct);
      end
   end

   // ---------------- monitor ----------------
   logic [MEM_W-1:0] mon_am, mon_pm, mon_em;
   logic [OUT_W-1:0] mon_ao, mon_po, mon_eo;
   bit               mon_mem_stall = 1'b0;
   bit               mon_out_stall = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            mon_mem_stall = 1'b0;
            mon_out_stall = 1'b0;
         end else begin
            mon_am = {bus.mem_addr, bus.mem_wen, bus.mem_wmask,
                      bus.mem_wen ? bus.mem_wdata : 32'd0};
            mon_ao = {bus.out_data, bus.out_rd, bus.out_wen, bus.out_err};
            if (mon_mem_stall) begin
               check("mem_hold_valid", bus.mem_valid, 1);
               check("mem_hold_payload", mon_am, mon_pm);
            end
            if (mon_out_stall) begin
               check("out_hold_valid", bus.out_valid, 1);
               check("out_hold_payload", mon_ao, mon_po);
            end
            if (bus.mem_valid || bus.out_valid) check("in_ready_busy", bus.in_ready, 0);
            if (bus.mem_valid && bus.mem_ready) begin
               if (exp_mem_q.size() == 0) begin
                  n_total++;
                  n_bad++;
                  $display("FAIL mem_unexpected: got request %0h expected none", mon_am);
               end else begin
                  mon_em = exp_mem_q.pop_front();
                  check("mem_req", mon_am, mon_em);
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  n_bad++;
                  $display("FAIL out_unexpected: got result %0h expected none", mon_ao);
               end else begin
                  mon_eo = exp_q.pop_front();
                  check("out_result", mon_ao, mon_eo);
               end
            end
            mon_mem_stall = bus.mem_valid && !bus.mem_ready;
            mon_out_stall = bus.out_valid && !bus.out_ready;
            mon_pm = mon_am;
            mon_po = mon_ao;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      bit st;
      logic [2:0]  f3;
      logic [31:0] base, imm;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_store  = 1'b0;
      bus.in_funct3 = 3'd0;
      bus.in_base   = 32'd0;
      bus.in_imm    = 32'd0;
      bus.in_wdata  = 32'd0;
      bus.in_rd     = 5'd0;
      repeat (3) @(negedge clk);
      #2;
      check_idle("reset");
      @(negedge clk);
      rst = 1'b0;

      // lw with immediate responses: latency and data pass-through
      issue(1'b0, 3'b010, 32'h8000_0000, 32'd4, 32'h0, 5'd3, 32'hDEAD_BEEF);
      #2;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         #2;
         lat++;
      end
      check("lw_latency", lat, 3);
      drain("lw");

      // lb / lbu at byte offset 3, sh at offset 2
      issue(1'b0, 3'b000, 32'h8000_0000, 32'd3, 32'h0, 5'd4, 32'h8012_3456);
      issue(1'b0, 3'b100, 32'h8000_0000, 32'd3, 32'h0, 5'd5, 32'h8012_3456);
      issue(1'b1, 3'b001, 32'h8000_0000, 32'd2, 32'h1234_ABCD, 5'd6, 32'h0);
      issue(1'b0, 3'b101, 32'h8000_0000, 32'd2, 32'h0, 5'd7, 32'h9ABC_1234);
      issue(1'b0, 3'b001, 32'h8000_0001, 32'd1, 32'h0, 5'd8, 32'h9ABC_1234);
      drain("directed");

      // Memory stall for 5 cycles, then writeback stall for 3 cycles
      @(negedge clk);
      #1;
      rdy_pct = 0;
      out_pct = 0;
      issue(1'b1, 3'b010, 32'h8000_0100, 32'd8, 32'hCAFE_F00D, 5'd10, 32'h0);
      repeat (5) @(negedge clk);
      #1;
      rdy_pct = 100;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(negedge clk);
         #2;
         lat++;
      end
      check("stall_out_valid", bus.out_valid, 1);
      repeat (3) @(negedge clk);
      #1;
      out_pct = 100;
      drain("stall");

`ifdef LSU_MISALIGN_TRAP_EN
      // Misaligned lw: no memory request, error result one cycle after accept
      issue(1'b0, 3'b010, 32'h8000_0000, 32'd1, 32'h0, 5'd11, 32'h0);
      #2;
      check("trap_out_valid", bus.out_valid, 1);
      check("trap_out_err", bus.out_err, 1);
      check("trap_mem_valid", bus.mem_valid, 0);
      drain("trap");
`endif

      // Reset while waiting for the response, then a late response pulse
      @(negedge clk);
      #1;
      resp_auto      = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      issue(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'h0, 5'd9, 32'h1111_2222);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #2;
      check("rst_pre_wait_state", dbg_state, 2);
      rst = 1'b1;
      @(negedge clk);
      rst            = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1111_2222;
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      if (rdata_q.size() != 0) void'(rdata_q.pop_front());
      #2;
      check_idle("rst_mid");
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #2;
      check_idle("rst_after_rvalid");
      repeat (4) begin
         @(negedge clk);
         #2;
         check("rst_no_out_valid", bus.out_valid, 0);
      end
      resp_auto = 1'b1;

      // Randomized traffic with varying back-pressure
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) begin
            @(negedge clk);
            #1;
            rdy_pct = $urandom_range(30, 100);
            rv_pct  = $urandom_range(30, 100);
            out_pct = $urandom_range(30, 100);
         end
         st   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         base = ($urandom_range(0, 1) == 1) ? $urandom : 32'h8000_0000 + 32'($urandom_range(0, 255));
         imm  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
         issue(st, f3, base, imm, $urandom, 5'($urandom_range(0, 31)), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      #1;
      rdy_pct = 100;
      rv_pct  = 100;
      out_pct = 100;
      drain("final");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
